// File: rtl/count_watch.sv
// Count watcher: flags compare matches (and, with COUNT_WATCH_WRAP_EN defined,
// all-ones->zero wraps) of an upstream counter and queues them in an event FIFO.
module count_watch #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CNT_W      = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [CNT_W-1:0] count_in,
    input  logic [CNT_W-1:0] cmp_value,
    input  logic             cmp_wr,
    input  logic             ovf_clr,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [CNT_W+1:0] evt_data,
    output logic             match_pulse,
    output logic             overflow
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned EW = CNT_W + 2;

    typedef enum logic [1:0] {
        DISARMED = 2'd0,
        ARMED    = 2'd1,
        LOCKOUT  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cmp_q, cmp_d;
    logic [EW-1:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             valid_q, valid_d;
    logic             pulse_q, pulse_d;
    logic             ovf_q, ovf_d;
    logic             is_match, is_wrap, push, pop, full, push_ok;
    logic [EW-1:0]    evt_word;
`ifdef COUNT_WATCH_WRAP_EN
    logic [CNT_W-1:0] prev_q, prev_d;
    logic             prev_valid_q, prev_valid_d;
`endif

    // Next-state logic for the compare FSM, wrap detector and FIFO bookkeeping
    always_comb begin
        state_d  = state_q;
        cmp_d    = cmp_q;
        is_match = 1'b0;
        is_wrap  = 1'b0;
`ifdef COUNT_WATCH_WRAP_EN
        prev_d       = count_in;
        prev_valid_d = 1'b1;
        is_wrap      = prev_valid_q && (prev_q == '1) && (count_in == '0);
`endif
        if (cmp_wr) begin
            cmp_d   = cmp_value;
            state_d = ARMED;
        end else begin
            case (state_q)
                ARMED: begin
                    if (count_in == cmp_q) begin
                        is_match = 1'b1;
                        state_d  = LOCKOUT;
                    end
                end
                LOCKOUT: begin
                    if (count_in != cmp_q) state_d = ARMED;
                end
                default: ;
            endcase
        end

        evt_word = {is_wrap, is_match, count_in};
        push     = is_match | is_wrap;
        pop      = valid_q & evt_ready;
        full     = (cnt_q == CW'(FIFO_DEPTH));
        // A pop on the same edge frees the slot, so a full FIFO can still accept
        push_ok  = push & (~full | pop);

        wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        cnt_d    = cnt_q + CW'(push_ok) - CW'(pop);
        valid_d  = (cnt_d != '0);
        pulse_d  = is_match;

        if (push && !push_ok) ovf_d = 1'b1;
        else if (ovf_clr)     ovf_d = 1'b0;
        else                  ovf_d = ovf_q;
    end

    // State and control registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= DISARMED;
            cmp_q        <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            cnt_q        <= '0;
            valid_q      <= 1'b0;
            pulse_q      <= 1'b0;
            ovf_q        <= 1'b0;
`ifdef COUNT_WATCH_WRAP_EN
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cmp_q        <= cmp_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            cnt_q        <= cnt_d;
            valid_q      <= valid_d;
            pulse_q      <= pulse_d;
            ovf_q        <= ovf_d;
`ifdef COUNT_WATCH_WRAP_EN
            prev_q       <= prev_d;
            prev_valid_q <= prev_valid_d;
`endif
        end
    end

    // Event storage; contents are don't-care while the FIFO is empty
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= evt_word;
    end

    assign evt_valid   = valid_q;
    assign evt_data    = mem_q[rd_ptr_q];
    assign match_pulse = pulse_q;
    assign overflow    = ovf_q;

endmodule
